text_console_writer: RTL
========================

Name: text_console_writer

Overview:
- Writer side of the text-mode character buffer. The VGA renderer reads this buffer: an 80x34 grid of cells at addresses 0..2719, one byte per cell, where bit 7 is the emphasized attribute and bits 6:0 are the glyph code.
- Accepts a stream of ASCII bytes over a valid/ready handshake and keeps a cursor.
- Emits write strobes to the buffer's write port for printable characters, control codes, full-screen clear and new-line clearing.

Parameters:
- COLS, 80, characters per row.
- ROWS, 34, rows per screen.
- CELLS, 2720, COLS*ROWS; buffer depth.
- ADDR_W, 12, buffer address width.
- BLANK, 8'h20, fill byte for cleared cells.

Ports:
- clk25mhz  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  8  ASCII byte (bit 7 ignored).
- emph_in  in  1  emphasized attribute for char_in.
- char_valid  in  1  char_in/emph_in valid.
- char_ready  out  1  block can accept a byte this cycle.
- clear_req  in  1  level request for full-screen clear.
- ram_we  out  1  buffer write strobe.
- ram_waddr  out  ADDR_W  buffer write address.
- ram_wdata  out  8  buffer write data, {attr, glyph[6:0]}.
- cursor_col  out  7  current column, 0..79.
- cursor_row  out  6  current row, 0..33.
- busy  out  1  high in CLEAR or CLRROW.

Behaviour:
- Clock/reset: one clock, clk25mhz; reset rst_n is asynchronous and active-low.
- Reset values: all outputs and registers 0, state IDLE, char_ready=0 while in reset. No automatic clear after reset.
- Reset mid-operation: aborts any fill immediately; the buffer contents left behind are undefined.
- Cursor address: keep a register cur_addr = row_base + col, with row_base stepped by ±COLS. No multiplier.
- All write-port outputs are registered. A byte accepted at edge N produces ram_we=1 in the cycle after N. ram_we is a single-cycle pulse per cell.
- Handshake:
  - char_ready = (state==IDLE) && !clear_req.
  - Transfer when char_valid && char_ready.
  - clear_req beats a pending char_valid in IDLE.
  - clear_req is ignored while busy; a level still high on return to IDLE starts a new clear.
- States:
  - IDLE.
  - CLEAR: fill all CELLS.
  - CLRROW: fill COLS cells of one row.
- IDLE, clear_req: enter CLEAR with fill address 0.
- IDLE, accepted byte, decoded on char_in[6:0]:
  - 0x20..0x7E printable: write {emph_in, char_in[6:0]} at cur_addr, then col+1. If col was 79: col=0, row advance.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: col=0, row advance, no write of its own.
  - 0x08 BS: if col>0, col-1 and write BLANK at the new position. At col 0, no-op; it never moves to the previous row.
  - 0x0C FF: same as clear_req (enter CLEAR).
  - Any other code: consumed, no write, no cursor change.
- Row advance: row+1, or wrap 33→0 (row_base back to 0). Then enter CLRROW for the destination row, so every newly entered row is blank.
- CLRROW: writes BLANK to row_base..row_base+79, one per cycle. Exactly 80 write cycles, then back to IDLE. A printable at col 79 first writes its own cell, then the 80 row-clear writes follow.
- CLEAR: writes BLANK to addresses 0..2719 ascending, one per cycle. Exactly 2720 write cycles. Cursor set to (0,0) on entry. Returns to IDLE after address 2719.
- Address never exceeds 2719.
- cursor_col/cursor_row always reflect the position for the next printable.

Decomposition:
- Shared package console_pkg:
  - COLS, ROWS, CELLS, BLANK.
  - Control codes CC_BS, CC_LF, CC_FF, CC_CR.
  - State enum {IDLE, CLEAR, CLRROW}.
- One natural sub-module, console_fill_engine: takes start address and count, produces a run of sequential BLANK writes and a done pulse. Used by both CLEAR and CLRROW.

Test Plan:
- Reset, then 'A' (0x41) with emph_in=1 → one cycle later ram_we=1, ram_waddr=0, ram_wdata=8'hC1; cursor_col=1.
- 80 printables from (0,0) → last write addr 79, then exactly 80 BLANK writes to addrs 80..159; busy and !char_ready for those 80 cycles; cursor (0,1).
- Cursor at (5,33), send 0x0A → 80 BLANK writes to addrs 0..79; cursor (0,0).
- Cursor (3,2), send 0x08 → BLANK written to addr 162, cursor (2,2). At (0,2), 0x08 → no write, cursor unchanged.
- clear_req and char_valid asserted together in IDLE → byte not accepted; 2720 writes to addrs 0..2719 in order; cursor (0,0); char_ready rises the cycle after the last write (clear_req low).
- rst_n dropped mid-CLEAR at fill addr 1000 → ram_we=0 immediately, all outputs 0. After release: IDLE, char_ready=1, no further writes.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants, control codes and types for the text-console writer.
package console_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 34;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 6;

    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [6:0] CC_BS = 7'h08;
    localparam logic [6:0] CC_LF = 7'h0A;
    localparam logic [6:0] CC_FF = 7'h0C;
    localparam logic [6:0] CC_CR = 7'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_CLRROW = 2'd2
    } state_e;

    // One write into the character buffer.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_s;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/console_fill_engine.sv
// Sequential address generator for runs of BLANK writes (full clear or one row).
module console_fill_engine
    import console_pkg::*;
(
    input  logic              clk25mhz,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic              we_c,
    output logic [ADDR_W-1:0] addr_c,
    output logic              last_c
);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;

    always_ff @(posedge clk25mhz or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            ptr_q    <= '0;
            remain_q <= '0;
        end else begin
            active_q <= active_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
        end
    end

    // remain_q counts writes still to go after the current one.
    always_comb begin
        active_d = active_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        if (start_i) begin
            active_d = 1'b1;
            ptr_d    = start_addr_i;
            remain_d = count_i - ADDR_W'(1);
        end else if (active_q) begin
            if (remain_q == '0) begin
                active_d = 1'b0;
            end else begin
                ptr_d    = ptr_q + ADDR_W'(1);
                remain_d = remain_q - ADDR_W'(1);
            end
        end
    end

    assign we_c   = active_q;
    assign addr_c = ptr_q;
    assign last_c = active_q && (remain_q == '0);

endmodule

// File: rtl/text_console_writer.sv
// Writer side of the 80x34 text buffer: byte stream in, cursor-tracked buffer writes out.
module text_console_writer
    import console_pkg::*;
(
    input  logic              clk25mhz,
    input  logic              rst_n,
    input  logic [7:0]        char_in,
    input  logic              emph_in,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              clear_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              run_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    wr_s               wr_q, wr_d;
    logic              we_q, we_d;
    logic              last_q, last_d;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] fill_count;
    logic              fill_we_c;
    logic [ADDR_W-1:0] fill_addr_c;
    logic              fill_last_c;

    logic              accept;
    logic              do_clear;
    logic              do_advance;
    logic [6:0]        code;

    console_fill_engine u_fill (
        .clk25mhz     (clk25mhz),
        .rst_n        (rst_n),
        .start_i      (fill_start),
        .start_addr_i (fill_addr),
        .count_i      (fill_count),
        .we_c         (fill_we_c),
        .addr_c       (fill_addr_c),
        .last_c       (fill_last_c)
    );

    // run_q holds char_ready low until the first edge after reset release.
    always_ff @(posedge clk25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            cur_q   <= '0;
            wr_q    <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            last_q  <= last_d;
        end
    end

    assign char_ready = run_q && (state_q == ST_IDLE) && !clear_req;
    assign accept     = char_valid && char_ready;
    assign code       = char_in[6:0];

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        base_d     = base_q;
        cur_d      = cur_q;
        wr_d       = wr_q;
        we_d       = 1'b0;
        last_d     = 1'b0;
        fill_start = 1'b0;
        fill_addr  = '0;
        fill_count = ADDR_W'(COLS);
        do_clear   = 1'b0;
        do_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_q && clear_req) begin
                    do_clear = 1'b1;
                end else if (accept) begin
                    if (is_printable(code)) begin
                        we_d    = 1'b1;
                        wr_d    = '{addr: cur_q, data: {emph_in, code}};
                        if (col_q == COL_W'(COLS - 1)) begin
                            do_advance = 1'b1;
                        end else begin
                            col_d = col_q + COL_W'(1);
                            cur_d = cur_q + ADDR_W'(1);
                        end
                    end else begin
                        case (code)
                            CC_CR: begin
                                col_d = '0;
                                cur_d = base_q;
                            end
                            CC_LF: do_advance = 1'b1;
                            CC_FF: do_clear   = 1'b1;
                            CC_BS: begin
                                if (col_q != '0) begin
                                    col_d = col_q - COL_W'(1);
                                    cur_d = cur_q - ADDR_W'(1);
                                    we_d  = 1'b1;
                                    wr_d  = '{addr: cur_q - ADDR_W'(1), data: BLANK};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_CLEAR, ST_CLRROW: begin
                if (fill_we_c) begin
                    we_d   = 1'b1;
                    wr_d   = '{addr: fill_addr_c, data: BLANK};
                    last_d = fill_last_c;
                end
                // Leave only once the final fill write has been presented.
                if (last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_clear) begin
            state_d    = ST_CLEAR;
            fill_start = 1'b1;
            fill_addr  = '0;
            fill_count = ADDR_W'(CELLS);
            col_d      = '0;
            row_d      = '0;
            base_d     = '0;
            cur_d      = '0;
        end

        // Every newly entered row is blanked before more text lands on it.
        if (do_advance) begin
            col_d = '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
                row_d  = '0;
                base_d = '0;
            end else begin
                row_d  = row_q + ROW_W'(1);
                base_d = base_q + ADDR_W'(COLS);
            end
            cur_d      = base_d;
            state_d    = ST_CLRROW;
            fill_start = 1'b1;
            fill_addr  = base_d;
            fill_count = ADDR_W'(COLS);
        end
    end

    assign ram_we     = we_q;
    assign ram_waddr  = wr_q.addr;
    assign ram_wdata  = wr_q.data;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
